// File: rtl/modport_pkg.sv
// Shared types and constants for the APB-style slave endpoint and its register bank.
package modport_pkg;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = ADDR_W - 2;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

endpackage

// File: rtl/modport_regbank.sv
// DEPTH x 32 word bank: one write port, one read port, async reset to zero.
module modport_regbank
  import modport_pkg::*;
#(
  parameter int unsigned       DEPTH    = 64,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_word_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_hit;
  logic              rd_hit;

  // The full index is compared so high address bits never alias into the bank.
  assign wr_hit = (32'(wr_idx_i) < DEPTH);
  assign rd_hit = (32'(rd_idx_i) < DEPTH);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (we_i && wr_hit) begin
      mem_q[wr_idx_i[AW-1:0]] <= wr_data_i;
    end
  end

  assign rd_word_o = rd_hit ? mem_q[rd_idx_i[AW-1:0]] : ERR_DATA;

endmodule

// File: rtl/modport_apb_slave.sv
// Zero-wait-state APB-style slave: setup/access FSM in front of a word register bank.
module modport_apb_slave
  import modport_pkg::*;
#(
  parameter int unsigned       DEPTH    = 64,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] bank_word;
  logic              bank_we;
  logic              unused_addr_lsb;

  assign word_idx        = addr[ADDR_W-1:2];
  assign unused_addr_lsb = ^addr[1:0];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    bank_we   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sel && !en) state_d = SETUP;
      end
      SETUP: begin
        if (!sel) begin
          state_d = IDLE;
        end else if (en) begin
          state_d = ACCESS;
          bank_we = wr_en;
        end else begin
          state_d = SETUP;
        end
      end
      ACCESS: begin
        // en still high here ends the transfer; only a fresh setup continues.
        if (sel && !en) state_d = SETUP;
        else            state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reads load at every setup-phase edge so data is valid for the whole access cycle.
    if (sel && !en && !wr_en) rd_data_d = bank_word;
  end

  modport_regbank #(
    .DEPTH    (DEPTH),
    .ERR_DATA (ERR_DATA)
  ) u_regbank (
    .clk_i     (sys_clk),
    .rst_ni    (rst_n),
    .we_i      (bank_we),
    .wr_idx_i  (word_idx),
    .wr_data_i (wr_data),
    .rd_idx_i  (word_idx),
    .rd_word_o (bank_word)
  );

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_modport_apb_slave.sv
// Transaction-level bench for modport_apb_slave with a word-array reference model.
module tb_modport_apb_slave;

  localparam int          DEPTH = 64;
  localparam logic [31:0] ERR   = 32'hDEAD_BEEF;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        en;
  logic [16:0] addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_rd;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 sys_clk = ~sys_clk;

  modport_apb_slave #(.DEPTH(DEPTH), .ERR_DATA(ERR)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .en      (en),
    .addr    (addr),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_data (rd_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: rd_data=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [16:0] a);
    int idx;
    idx = int'(a[16:2]);
    return (idx < DEPTH) ? ref_mem[idx] : ERR;
  endfunction

  task automatic ref_clear();
    foreach (ref_mem[i]) ref_mem[i] = '0;
    exp_rd = '0;
  endtask

  task automatic bus_idle();
    @(negedge sys_clk);
    sel = 1'b0;
    en  = 1'b0;
  endtask

  task automatic wr_xfer(input logic [16:0] a, input logic [31:0] d);
    int idx;
    @(negedge sys_clk);
    sel = 1'b1; en = 1'b0; wr_en = 1'b1; addr = a; wr_data = d;
    @(negedge sys_clk);
    en = 1'b1;
    #1 check_eq("wr_hold", rd_data, exp_rd);
    idx = int'(a[16:2]);
    if (idx < DEPTH) ref_mem[idx] = d;
  endtask

  task automatic rd_xfer(input logic [16:0] a, input string tag);
    @(negedge sys_clk);
    sel = 1'b1; en = 1'b0; wr_en = 1'b0; addr = a;
    @(negedge sys_clk);
    en = 1'b1;
    exp_rd = ref_read(a);
    #1 check_eq(tag, rd_data, exp_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [16:0] ra;
    logic [31:0] rdat;
    int          op;

    rst_n = 1'b0; sel = 1'b0; en = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0;
    ref_clear();
    repeat (3) @(negedge sys_clk);
    check_eq("reset_rd", rd_data, 32'h0);
    rst_n = 1'b1;

    rd_xfer(17'h000, "rd_after_reset");
    bus_idle();

    wr_xfer(17'h010, 32'hA5A5_1234);
    bus_idle();
    rd_xfer(17'h010, "rd_010");
    rd_xfer(17'h014, "rd_014");
    bus_idle();

    wr_xfer(17'h000, 32'h1111_1111);
    wr_xfer(17'h0FC, 32'h2222_2222);
    bus_idle();
    rd_xfer(17'h000, "rd_first");
    rd_xfer(17'h0FC, "rd_last");
    bus_idle();

    wr_xfer(17'h1_0000, 32'h5555_5555);
    bus_idle();
    rd_xfer(17'h1_0000, "rd_oor_high");
    rd_xfer(17'h100, "rd_oor_100");
    rd_xfer(17'h000, "rd_no_alias");
    rd_xfer(17'h013, "rd_lsb_ignored");
    bus_idle();

    // en without a setup phase must not write.
    @(negedge sys_clk);
    sel = 1'b1; en = 1'b1; wr_en = 1'b1; addr = 17'h020; wr_data = 32'h7777_7777;
    repeat (2) @(negedge sys_clk);
    sel = 1'b0; en = 1'b0;
    rd_xfer(17'h020, "rd_no_setup");
    bus_idle();

    // sel dropped where the access phase should be: transfer abandoned.
    @(negedge sys_clk);
    sel = 1'b1; en = 1'b0; wr_en = 1'b1; addr = 17'h040; wr_data = 32'h4040_4040;
    @(negedge sys_clk);
    sel = 1'b0; en = 1'b1;
    @(negedge sys_clk);
    en = 1'b0;
    rd_xfer(17'h040, "rd_sel_drop");
    bus_idle();

    // en held past access must not start a second write.
    wr_xfer(17'h044, 32'h0000_0A0A);
    @(negedge sys_clk);
    wr_data = 32'h0000_0B0B;
    bus_idle();
    rd_xfer(17'h044, "rd_en_held");
    bus_idle();

    wr_xfer(17'h008, 32'hCAFE_0001);
    rd_xfer(17'h008, "rd_back2back");
    bus_idle();

    // Asynchronous reset between clock edges.
    @(negedge sys_clk);
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset", rd_data, 32'h0);
    sel = 1'b0; en = 1'b0;
    ref_clear();
    @(negedge sys_clk);
    rst_n = 1'b1;
    rd_xfer(17'h010, "rd_bank_cleared");
    bus_idle();

    wr_xfer(17'h030, 32'h3030_3030);
    bus_idle();
    @(negedge sys_clk);
    sel = 1'b1; en = 1'b0; wr_en = 1'b1; addr = 17'h030; wr_data = 32'h9999_9999;
    @(negedge sys_clk);
    en = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1; sel = 1'b0; en = 1'b0;
    ref_clear();
    rd_xfer(17'h030, "rd_reset_in_access");
    bus_idle();

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 9) == 0) ra = 17'($urandom);
      else ra = {15'($urandom_range(0, DEPTH + 7)), 2'($urandom)};
      rdat = $urandom;
      op = $urandom_range(0, 9);
      if (op < 4) begin
        wr_xfer(ra, rdat);
      end else if (op == 4) begin
        @(negedge sys_clk);
        sel = 1'b1; en = 1'b0; wr_en = 1'b1; addr = ra; wr_data = rdat;
        @(negedge sys_clk);
        sel = 1'b0; en = 1'b1;
      end else begin
        rd_xfer(ra, "rand_rd");
      end
      if ($urandom_range(0, 2) == 0) bus_idle();
    end
    bus_idle();

    for (int i = 0; i < DEPTH; i += 7) rd_xfer(17'(i * 4), "sweep_rd");
    bus_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
